// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache sequencing controller.
package cache_ctrl_pkg;

   // Controller states: wait for a request, resolve hit/miss, evict, refill.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHECK     = 2'd1,
      WRITEBACK = 2'd2,
      FILL      = 2'd3
   } state_e;

   // Per-way data array write-enable sources.
   localparam logic [1:0] WSEL_NONE = 2'b00;
   localparam logic [1:0] WSEL_CPU  = 2'b01;
   localparam logic [1:0] WSEL_FILL = 2'b10;

   // Physical memory address source.
   localparam logic PSEL_MISS = 1'b0;
   localparam logic PSEL_WB   = 1'b1;

endpackage

// File: rtl/cache_event_counter.sv
// Free-running event counter that wraps modulo 2^CNT_W.
module cache_event_counter
   import cache_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Advance by one on each event strobe; natural overflow gives the wrap.
   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back cache: serves CPU requests,
// drives datapath strobes, runs writeback/fill handshakes, counts events.
module cache_control
   import cache_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic             hit0,
   input  logic             hit1,
   input  logic             valid_bit,
   input  logic             dirty_bit,
   input  logic             lru_out,
   output logic             read_array,
   output logic             write_array,
   output logic             lru_load,
   output logic             data_select,
   output logic             dirty_select,
   output logic             pmem_select,
   output logic [1:0]       write0_select,
   output logic [1:0]       write1_select,
   output logic             valid_load0,
   output logic             valid_load1,
   output logic             tag_load0,
   output logic             tag_load1,
   output logic             dirty_load0,
   output logic             dirty_load1,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   state_e state_q;
   state_e state_d;
   logic   refill_q;
   logic   refill_d;
   logic   hitInc;
   logic   missInc;
   logic   wbInc;
   logic   reqAny;
   logic   anyHit;

   assign reqAny = mem_read | mem_write;
   assign anyHit = hit0 | hit1;

   // State register; refill_q marks a CHECK that follows a completed fill,
   // so that re-check does not count as a fresh hit or miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         refill_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
      end
   end

   // Next-state and strobe decode; a simultaneous read+write takes the write path.
   always_comb begin
      state_d       = state_q;
      refill_d      = 1'b0;
      hitInc        = 1'b0;
      missInc       = 1'b0;
      wbInc         = 1'b0;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      read_array    = 1'b0;
      write_array   = 1'b0;
      lru_load      = 1'b0;
      data_select   = 1'b0;
      dirty_select  = 1'b0;
      pmem_select   = PSEL_MISS;
      write0_select = WSEL_NONE;
      write1_select = WSEL_NONE;
      valid_load0   = 1'b0;
      valid_load1   = 1'b0;
      tag_load0     = 1'b0;
      tag_load1     = 1'b0;
      dirty_load0   = 1'b0;
      dirty_load1   = 1'b0;
      unique case (state_q)
         IDLE: begin
            read_array  = mem_read;
            write_array = mem_write;
            if (reqAny) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            read_array  = mem_read;
            write_array = mem_write;
            if (!reqAny) begin
               state_d = IDLE;
            end else if (anyHit) begin
               mem_resp = 1'b1;
               lru_load = 1'b1;
               hitInc   = ~refill_q;
               if (mem_write) begin
                  dirty_select = 1'b1;
                  if (hit0) begin
                     write0_select = WSEL_CPU;
                     dirty_load0   = 1'b1;
                  end else begin
                     write1_select = WSEL_CPU;
                     dirty_load1   = 1'b1;
                  end
               end
               state_d = IDLE;
            end else begin
               missInc = ~refill_q;
               if (valid_bit && dirty_bit) begin
                  wbInc   = 1'b1;
                  state_d = WRITEBACK;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WRITEBACK: begin
            pmem_write  = 1'b1;
            pmem_select = PSEL_WB;
            if (pmem_resp) begin
               state_d = FILL;
            end
         end
         FILL: begin
            pmem_read   = 1'b1;
            pmem_select = PSEL_MISS;
            if (pmem_resp) begin
               data_select = 1'b1;
               if (!lru_out) begin
                  write0_select = WSEL_FILL;
                  tag_load0     = 1'b1;
                  valid_load0   = 1'b1;
                  dirty_load0   = 1'b1;
               end else begin
                  write1_select = WSEL_FILL;
                  tag_load1     = 1'b1;
                  valid_load1   = 1'b1;
                  dirty_load1   = 1'b1;
               end
               refill_d = 1'b1;
               state_d  = CHECK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   cache_event_counter #(.CNT_W(CNT_W)) uHitCounter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (hitInc),
      .count_o (hit_count)
   );

   cache_event_counter #(.CNT_W(CNT_W)) uMissCounter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (missInc),
      .count_o (miss_count)
   );

   cache_event_counter #(.CNT_W(CNT_W)) uWbCounter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (wbInc),
      .count_o (wb_count)
   );

endmodule

// File: tb/tb_cache_control.sv
// Randomized self-checking bench for cache_control against a
// transaction-level model of request outcomes and event counts.
module tb_cache_control;

   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic          mem_read;
   logic          mem_write;
   logic          mem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic          pmem_resp;
   logic          hit0;
   logic          hit1;
   logic          valid_bit;
   logic          dirty_bit;
   logic          lru_out;
   logic          read_array;
   logic          write_array;
   logic          lru_load;
   logic          data_select;
   logic          dirty_select;
   logic          pmem_select;
   logic [1:0]    write0_select;
   logic [1:0]    write1_select;
   logic          valid_load0;
   logic          valid_load1;
   logic          tag_load0;
   logic          tag_load1;
   logic          dirty_load0;
   logic          dirty_load1;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;
   logic [CW-1:0] wb_count;

   // Expected strobes for the current cycle
   logic          e_mem_resp;
   logic          e_pmem_read;
   logic          e_pmem_write;
   logic          e_read_array;
   logic          e_write_array;
   logic          e_lru_load;
   logic          e_data_select;
   logic          e_dirty_select;
   logic          e_pmem_select;
   logic [1:0]    e_write0_select;
   logic [1:0]    e_write1_select;
   logic          e_valid_load0;
   logic          e_valid_load1;
   logic          e_tag_load0;
   logic          e_tag_load1;
   logic          e_dirty_load0;
   logic          e_dirty_load1;

   // Reference event tallies
   int hitModel;
   int missModel;
   int wbModel;

   int errorCount;
   int checkCount;

   cache_control #(.CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_resp      (mem_resp),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_resp     (pmem_resp),
      .hit0          (hit0),
      .hit1          (hit1),
      .valid_bit     (valid_bit),
      .dirty_bit     (dirty_bit),
      .lru_out       (lru_out),
      .read_array    (read_array),
      .write_array   (write_array),
      .lru_load      (lru_load),
      .data_select   (data_select),
      .dirty_select  (dirty_select),
      .pmem_select   (pmem_select),
      .write0_select (write0_select),
      .write1_select (write1_select),
      .valid_load0   (valid_load0),
      .valid_load1   (valid_load1),
      .tag_load0     (tag_load0),
      .tag_load1     (tag_load1),
      .dirty_load0   (dirty_load0),
      .dirty_load1   (dirty_load1),
      .hit_count     (hit_count),
      .miss_count    (miss_count),
      .wb_count      (wb_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Pack every single-cycle strobe so one comparison covers a whole cycle.
   function automatic logic [18:0] actVec();
      return {mem_resp, pmem_read, pmem_write, read_array, write_array, lru_load,
              data_select, dirty_select, pmem_select, write0_select, write1_select,
              valid_load0, valid_load1, tag_load0, tag_load1, dirty_load0, dirty_load1};
   endfunction

   function automatic logic [18:0] expVec();
      return {e_mem_resp, e_pmem_read, e_pmem_write, e_read_array, e_write_array, e_lru_load,
              e_data_select, e_dirty_select, e_pmem_select, e_write0_select, e_write1_select,
              e_valid_load0, e_valid_load1, e_tag_load0, e_tag_load1, e_dirty_load0, e_dirty_load1};
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic clearExp();
      e_mem_resp      = 1'b0;
      e_pmem_read     = 1'b0;
      e_pmem_write    = 1'b0;
      e_read_array    = 1'b0;
      e_write_array   = 1'b0;
      e_lru_load      = 1'b0;
      e_data_select   = 1'b0;
      e_dirty_select  = 1'b0;
      e_pmem_select   = 1'b0;
      e_write0_select = 2'b00;
      e_write1_select = 2'b00;
      e_valid_load0   = 1'b0;
      e_valid_load1   = 1'b0;
      e_tag_load0     = 1'b0;
      e_tag_load1     = 1'b0;
      e_dirty_load0   = 1'b0;
      e_dirty_load1   = 1'b0;
   endtask

   // Expected strobes for a hit response on a given way.
   task automatic expectHit(input logic isWrite, input int way);
      e_mem_resp = 1'b1;
      e_lru_load = 1'b1;
      if (isWrite) begin
         e_dirty_select = 1'b1;
         if (way == 0) begin
            e_write0_select = 2'b01;
            e_dirty_load0   = 1'b1;
         end else begin
            e_write1_select = 2'b01;
            e_dirty_load1   = 1'b1;
         end
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleVec(input string tag);
      @(negedge clk);
      checkOutput(tag, 32'(actVec()), 32'(expVec()));
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "-hits"}, 32'(hit_count), 32'(hitModel % (1 << CW)));
      checkOutput({tag, "-miss"}, 32'(miss_count), 32'(missModel % (1 << CW)));
      checkOutput({tag, "-wbs"}, 32'(wb_count), 32'(wbModel % (1 << CW)));
   endtask

   // Idle cycles with stray pmem_resp and noisy hit lines: nothing may move.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         pmem_resp = 1'($urandom_range(0, 1));
         hit0      = 1'($urandom_range(0, 1));
         hit1      = 1'($urandom_range(0, 1));
         clearExp();
         sampleVec("idleGap");
         nextCycle();
      end
      pmem_resp = 1'b0;
   endtask

   // One CPU transaction. hitWay: 0 miss, 1 way0, 2 way1. Starts and ends
   // just after a rising edge with the controller idle.
   task automatic applyStimulus(input logic rd, input logic wr, input int hitWay,
                                input logic vValid, input logic vDirty, input logic lru,
                                input int wbLat, input int fillLat, input logic dropMid);
      logic isWrite;
      logic dirtyMiss;
      logic curRd;
      logic curWr;
      isWrite   = wr;
      dirtyMiss = vValid & vDirty;
      curRd     = rd;
      curWr     = wr;
      mem_read  = rd;
      mem_write = wr;
      hit0      = (hitWay == 1);
      hit1      = (hitWay == 2);
      valid_bit = vValid;
      dirty_bit = vDirty;
      lru_out   = lru;
      pmem_resp = 1'($urandom_range(0, 1));
      clearExp();
      e_read_array  = rd;
      e_write_array = wr;
      sampleVec("reqIdle");
      nextCycle();

      pmem_resp = 1'($urandom_range(0, 1));
      clearExp();
      e_read_array  = rd;
      e_write_array = wr;
      if (hitWay != 0) begin
         expectHit(isWrite, hitWay - 1);
         hitModel++;
      end else begin
         missModel++;
         if (dirtyMiss) begin
            wbModel++;
         end
      end
      sampleVec(hitWay != 0 ? "hitCheck" : "missCheck");
      nextCycle();

      if (hitWay == 0) begin
         if (dirtyMiss) begin
            for (int i = 1; i <= wbLat; i++) begin
               pmem_resp = (i == wbLat);
               hit0      = 1'($urandom_range(0, 1));
               hit1      = 1'($urandom_range(0, 1));
               clearExp();
               e_pmem_write  = 1'b1;
               e_pmem_select = 1'b1;
               sampleVec("writeback");
               nextCycle();
            end
         end
         if (dropMid) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            curRd     = 1'b0;
            curWr     = 1'b0;
         end
         for (int i = 1; i <= fillLat; i++) begin
            pmem_resp = (i == fillLat);
            hit0      = 1'($urandom_range(0, 1));
            hit1      = 1'($urandom_range(0, 1));
            clearExp();
            e_pmem_read = 1'b1;
            if (i == fillLat) begin
               e_data_select = 1'b1;
               if (lru == 1'b0) begin
                  e_write0_select = 2'b10;
                  e_tag_load0     = 1'b1;
                  e_valid_load0   = 1'b1;
                  e_dirty_load0   = 1'b1;
               end else begin
                  e_write1_select = 2'b10;
                  e_tag_load1     = 1'b1;
                  e_valid_load1   = 1'b1;
                  e_dirty_load1   = 1'b1;
               end
            end
            sampleVec(i == fillLat ? "fillDone" : "fillWait");
            nextCycle();
         end
         pmem_resp = 1'b0;
         hit0      = (lru == 1'b0);
         hit1      = (lru == 1'b1);
         clearExp();
         e_read_array  = curRd;
         e_write_array = curWr;
         if (curRd | curWr) begin
            expectHit(isWrite, int'(lru));
         end
         sampleVec("recheck");
         nextCycle();
      end

      mem_read  = 1'b0;
      mem_write = 1'b0;
      hit0      = 1'b0;
      hit1      = 1'b0;
      pmem_resp = 1'b0;
   endtask

   initial begin
      errorCount = 0;
      checkCount = 0;
      hitModel   = 0;
      missModel  = 0;
      wbModel    = 0;
      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      pmem_resp  = 1'b0;
      hit0       = 1'b0;
      hit1       = 1'b0;
      valid_bit  = 1'b0;
      dirty_bit  = 1'b0;
      lru_out    = 1'b0;
      clearExp();
      repeat (2) @(posedge clk);
      #1;
      sampleVec("resetState");
      checkCounters("reset");
      nextCycle();
      rst = 1'b0;
      nextCycle();

      $display("[TB] directed hits");
      applyStimulus(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
      checkCounters("readHit0");
      applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
      checkCounters("writeHit1");

      $display("[TB] directed misses");
      applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1, 5, 1'b0);
      checkCounters("cleanMiss");
      applyStimulus(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 3, 2, 1'b0);
      checkCounters("dirtyMiss");
      applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
      checkCounters("rdWrTogether");
      applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b1, 2, 3, 1'b1);
      checkCounters("dropMidMiss");
      idleCycles(4);
      checkCounters("strayResp");

      $display("[TB] randomized transactions");
      for (int t = 0; t < 60; t++) begin
         int   op;
         int   hw;
         logic dr;
         op = $urandom_range(0, 2);
         hw = $urandom_range(0, 2);
         dr = ($urandom_range(0, 5) == 0);
         applyStimulus(op != 1, op != 0, hw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4),
                       (hw == 0) && dr);
         checkCounters("random");
         idleCycles($urandom_range(0, 2));
      end

      $display("[TB] reset during fill");
      mem_read  = 1'b1;
      valid_bit = 1'b0;
      dirty_bit = 1'b0;
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("fillActive", 32'(pmem_read), 32'd1);
      #2;
      rst       = 1'b1;
      mem_read  = 1'b0;
      hitModel  = 0;
      missModel = 0;
      wbModel   = 0;
      #1;
      checkOutput("rstPmemDrop", 32'(pmem_read), 32'd0);
      clearExp();
      checkOutput("rstOutputs", 32'(actVec()), 32'(expVec()));
      checkCounters("rstMidFill");
      nextCycle();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
      checkCounters("afterReset");

      $display("[TB] hit counter wrap");
      for (int i = 0; i < (1 << CW) - 1; i++) begin
         applyStimulus(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
      end
      checkOutput("hitWrap", 32'(hit_count), 32'(hitModel % (1 << CW)));
      checkOutput("hitWrapZero", 32'(hit_count), 32'd0);
      checkCounters("wrap");

      $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
